sd_spi_master: RTL and testbench



---
 rtl/sd_spi_pkg.sv | 15 +
 rtl/sd_spi_master.sv | 96 +++++++++
 tb/tb_sd_spi_master.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI master.
// Divider presets are SCK half-period minus one, in 25 MHz clk_sys cycles.
package sd_spi_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOW,
      HIGH
   } state_t;

   localparam int         DIV_W_DEFAULT = 8;
   localparam logic [7:0] SD_INIT_DIV   = 8'd31;  // ~390 kHz for card init
   localparam logic [7:0] SD_FAST_DIV   = 8'd0;   // clk_sys/2 for data

endpackage

// File: rtl/sd_spi_master.sv
// Byte-wide SPI mode-0 master for the SD link: start/done handshake, MSB first,
// programmable SCK half-period, all outputs registered.
module sd_spi_master
   import sd_spi_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEFAULT
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic [DIV_W-1:0] clk_div,
   input  logic             cs_n_req,
   input  logic             start,
   input  logic [7:0]       tx_data,
   output logic             busy,
   output logic             done,
   output logic [7:0]       rx_data,
   output logic             sck,
   output logic             mosi,
   input  logic             miso,
   output logic             ss
);

   state_t           state;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       tx_sh;
   logic [7:0]       rx_sh;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         sck     <= 1'b0;
         mosi    <= 1'b1;
         ss      <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         rx_data <= 8'h00;
         div_q   <= '0;
         cnt     <= '0;
         bit_cnt <= 3'd0;
         tx_sh   <= 8'h00;
         rx_sh   <= 8'h00;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // ss only follows the request between bytes, never mid-byte
               ss <= cs_n_req;
               if (start) begin
                  tx_sh   <= tx_data;
                  div_q   <= clk_div;
                  cnt     <= clk_div;
                  mosi    <= tx_data[7];
                  bit_cnt <= 3'd0;
                  busy    <= 1'b1;
                  state   <= LOW;
               end
            end
            LOW: begin
               if (cnt == '0) begin
                  sck   <= 1'b1;
                  rx_sh <= {rx_sh[6:0], miso};
                  cnt   <= div_q;
                  state <= HIGH;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            HIGH: begin
               if (cnt == '0) begin
                  sck <= 1'b0;
                  if (bit_cnt == 3'd7) begin
                     // all eight bits were captured on the rising edges
                     rx_data <= rx_sh;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     mosi    <= 1'b1;
                     state   <= IDLE;
                  end else begin
                     tx_sh   <= {tx_sh[6:0], 1'b0};
                     mosi    <= tx_sh[6];
                     bit_cnt <= bit_cnt + 3'd1;
                     cnt     <= div_q;
                     state   <= LOW;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_spi_master.sv
// Directed bench for sd_spi_master: scoreboard of expected rx bytes, loopback
// and a small SD-card responder model on miso.
module tb_sd_spi_master;

   logic       clk_sys = 1'b0;
   logic       reset;
   logic [7:0] clk_div;
   logic       cs_n_req;
   logic       start;
   logic [7:0] tx_data;
   logic       busy;
   logic       done;
   logic [7:0] rx_data;
   logic       sck;
   logic       mosi;
   logic       miso;
   logic       ss;

   sd_spi_master #(.DIV_W(8)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .clk_div (clk_div),
      .cs_n_req(cs_n_req),
      .start   (start),
      .tx_data (tx_data),
      .busy    (busy),
      .done    (done),
      .rx_data (rx_data),
      .sck     (sck),
      .mosi    (mosi),
      .miso    (miso),
      .ss      (ss)
   );

   always #20 clk_sys = ~clk_sys;

   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   logic [7:0] sb[$];

   // card / line model state
   bit         loop = 1'b1;
   logic [7:0] card_byte = 8'hFF;
   logic [2:0] bidx = 3'd0;
   logic [7:0] mosi_sh = 8'h00;
   logic [7:0] cap_q[$];
   int         rises = 0;
   int         done_cnt = 0;
   int         phase_bad = 0;
   int         exp_phase = 1;
   bit         phase_watch = 1'b0;
   int         init_bad = 0;
   bit         init_watch = 1'b0;
   logic       sck_prev = 1'b0;
   int         last_edge = 0;
   bit         have_last = 1'b0;

   assign miso = loop ? mosi : card_byte[3'd7 - bidx];

   always @(posedge clk_sys) cyc <= cyc + 1;

   always @(posedge sck or posedge reset) begin
      if (reset) begin
         bidx = 3'd0;
      end else begin
         rises   = rises + 1;
         mosi_sh = {mosi_sh[6:0], mosi};
         bidx    = bidx + 3'd1;
         if (bidx == 3'd0) cap_q.push_back(mosi_sh);
      end
   end

   always @(negedge clk_sys) begin
      if (done === 1'b1) done_cnt = done_cnt + 1;
      if (init_watch && (ss !== 1'b1 || mosi !== 1'b1)) init_bad = init_bad + 1;
      if (sck !== sck_prev) begin
         if (have_last && phase_watch && (cyc - last_edge) != exp_phase)
            phase_bad = phase_bad + 1;
         last_edge = cyc;
         have_last = 1'b1;
      end
      sck_prev = sck;
      if (busy !== 1'b1) have_last = 1'b0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         failures = failures + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Call at a negedge; start is held for exactly one active edge.
   task automatic begin_xfer(input logic [7:0] tx, input logic [7:0] div,
                             input logic [7:0] exp, output int t0);
      tx_data = tx;
      clk_div = div;
      start   = 1'b1;
      t0      = cyc;
      sb.push_back(exp);
      @(negedge clk_sys);
      start = 1'b0;
   endtask

   // Returns at the negedge on which done is seen.
   task automatic finish_xfer(input logic [7:0] div, input int t0);
      bit         got;
      logic [7:0] e;
      got = 1'b0;
      for (int i = 0; i < 20000 && !got; i++) begin
         @(negedge clk_sys);
         if (done === 1'b1) got = 1'b1;
      end
      chk("done_seen", {31'd0, got}, 32'd1);
      if (sb.size() > 0) e = sb.pop_front();
      else e = 8'hxx;
      if (got) begin
         chk("latency", cyc - t0 - 1, 16 * (int'(div) + 1));
         chk("rx_data", {24'd0, rx_data}, {24'd0, e});
         chk("busy_at_done", {31'd0, busy}, 32'd0);
      end
   endtask

   task automatic xfer(input logic [7:0] tx, input logic [7:0] div, input logic [7:0] exp);
      int t0;
      begin_xfer(tx, div, exp, t0);
      finish_xfer(div, t0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         t0;
      int         r0;
      int         d0;
      bit         cmd_ok;
      bit         got01;
      logic [7:0] cmd[6];
      cmd = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};

      reset    = 1'b1;
      start    = 1'b0;
      cs_n_req = 1'b1;
      clk_div  = 8'd0;
      tx_data  = 8'h00;
      repeat (3) @(negedge clk_sys);
      reset = 1'b0;
      repeat (2) @(negedge clk_sys);
      chk("rst_sck", {31'd0, sck}, 32'd0);
      chk("rst_mosi", {31'd0, mosi}, 32'd1);
      chk("rst_ss", {31'd0, ss}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_rx", {24'd0, rx_data}, 32'd0);

      // reset mid-byte
      cs_n_req = 1'b0;
      repeat (2) @(negedge clk_sys);
      begin_xfer(8'h00, 8'd3, 8'h00, t0);
      repeat (4) @(negedge clk_sys);
      chk("pre_busy", {31'd0, busy}, 32'd1);
      chk("pre_ss", {31'd0, ss}, 32'd0);
      chk("pre_sck", {31'd0, sck}, 32'd1);
      chk("pre_mosi", {31'd0, mosi}, 32'd0);
      reset = 1'b1;
      #1;
      chk("arst_sck", {31'd0, sck}, 32'd0);
      chk("arst_mosi", {31'd0, mosi}, 32'd1);
      chk("arst_ss", {31'd0, ss}, 32'd1);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      d0 = done_cnt;
      @(negedge clk_sys);
      reset = 1'b0;
      repeat (80) @(negedge clk_sys);
      chk("arst_no_done", done_cnt - d0, 32'd0);
      sb.delete();

      // loopback, fastest clock
      loop = 1'b1;
      r0 = rises;
      cap_q.delete();
      xfer(8'hA5, 8'd0, 8'hA5);
      chk("lb_rises", rises - r0, 32'd8);
      chk("lb_mosi_idle", {31'd0, mosi}, 32'd1);
      chk("lb_mosi_cnt", cap_q.size(), 32'd1);
      if (cap_q.size() > 0) chk("lb_mosi_pat", {24'd0, cap_q[0]}, 32'hA5);
      @(negedge clk_sys);
      chk("done_pulse", {31'd0, done}, 32'd0);

      // responder returns 3C, D=4
      loop        = 1'b0;
      card_byte   = 8'h3C;
      exp_phase   = 4;
      phase_bad   = 0;
      phase_watch = 1'b1;
      xfer(8'hFF, 8'd3, 8'h3C);
      phase_watch = 1'b0;
      chk("phase_len", phase_bad, 32'd0);

      // ss frozen mid-byte, start while busy ignored
      loop     = 1'b1;
      cs_n_req = 1'b1;
      repeat (3) @(negedge clk_sys);
      chk("ss_idle_hi", {31'd0, ss}, 32'd1);
      r0 = rises;
      d0 = done_cnt;
      begin_xfer(8'h55, 8'd1, 8'h55, t0);
      repeat (6) @(negedge clk_sys);
      cs_n_req = 1'b0;
      @(negedge clk_sys);
      tx_data = 8'h00;
      start   = 1'b1;
      @(negedge clk_sys);
      start = 1'b0;
      chk("ss_mid", {31'd0, ss}, 32'd1);
      finish_xfer(8'd1, t0);
      chk("ss_at_done", {31'd0, ss}, 32'd1);
      @(negedge clk_sys);
      chk("ss_after", {31'd0, ss}, 32'd0);
      repeat (60) @(negedge clk_sys);
      chk("busy_start_rises", rises - r0, 32'd8);
      chk("busy_start_dones", done_cnt - d0, 32'd1);

      // init dummy clocks: ten back-to-back FF bytes, ss high
      cs_n_req = 1'b1;
      repeat (2) @(negedge clk_sys);
      init_bad   = 0;
      init_watch = 1'b1;
      r0 = rises;
      for (int i = 0; i < 10; i++) xfer(8'hFF, 8'd31, 8'hFF);
      init_watch = 1'b0;
      chk("init_rises", rises - r0, 32'd80);
      chk("init_ss_mosi", init_bad, 32'd0);

      // CMD0 to the card model, then poll for R1 = 01
      cs_n_req  = 1'b0;
      loop      = 1'b0;
      card_byte = 8'hFF;
      repeat (2) @(negedge clk_sys);
      cap_q.delete();
      for (int i = 0; i < 6; i++) xfer(cmd[i], 8'd0, 8'hFF);
      chk("cmd_bytes", cap_q.size(), 32'd6);
      cmd_ok = (cap_q.size() == 6);
      for (int i = 0; i < 6 && i < cap_q.size(); i++) begin
         chk("cmd_byte", {24'd0, cap_q[i]}, {24'd0, cmd[i]});
         if (cap_q[i] !== cmd[i]) cmd_ok = 1'b0;
      end
      got01 = 1'b0;
      for (int p = 0; p < 8 && !got01; p++) begin
         card_byte = (cmd_ok && p == 1) ? 8'h01 : 8'hFF;
         xfer(8'hFF, 8'd0, card_byte);
         if (rx_data === 8'h01) got01 = 1'b1;
      end
      chk("r1_seen", {31'd0, got01}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
